// File: rtl/flag_pkg.sv
// Shared types for the ALU flag consumer: branch kinds, LEGv8 condition
// codes and the architectural {N,Z,C,V} flag bundle.
package flag_pkg;

   typedef enum logic [1:0] {
      BR_NONE = 2'd0,
      BR_COND = 2'd1,
      BR_CBZ  = 2'd2,
      BR_CBNZ = 2'd3
   } br_type_t;

   typedef enum logic [3:0] {
      COND_EQ = 4'd0,
      COND_NE = 4'd1,
      COND_HS = 4'd2,
      COND_LO = 4'd3,
      COND_MI = 4'd4,
      COND_PL = 4'd5,
      COND_VS = 4'd6,
      COND_VC = 4'd7,
      COND_HI = 4'd8,
      COND_LS = 4'd9,
      COND_GE = 4'd10,
      COND_LT = 4'd11,
      COND_GT = 4'd12,
      COND_LE = 4'd13,
      COND_AL = 4'd14,
      COND_NV = 4'd15
   } cond_t;

   // Bit order matches the external view {N,Z,C,V}.
   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;

   localparam flags_t FLAG_RESET = '0;

endpackage

// File: rtl/cond_eval.sv
// Pure combinational LEGv8 condition evaluator. C=1 after a subtract means
// "no borrow", so HS/LO/HI/LS follow the A+~B+1 carry convention.
module cond_eval
   import flag_pkg::*;
(
   input  flags_t flags,
   input  cond_t  cond,
   output logic   taken
);

   // Decode the condition code against the supplied flags.
   always_comb begin
      taken = 1'b1;
      case (cond)
         COND_EQ: taken = flags.z;
         COND_NE: taken = !flags.z;
         COND_HS: taken = flags.c;
         COND_LO: taken = !flags.c;
         COND_MI: taken = flags.n;
         COND_PL: taken = !flags.n;
         COND_VS: taken = flags.v;
         COND_VC: taken = !flags.v;
         COND_HI: taken = flags.c && !flags.z;
         COND_LS: taken = !flags.c || flags.z;
         COND_GE: taken = (flags.n == flags.v);
         COND_LT: taken = (flags.n != flags.v);
         COND_GT: taken = !flags.z && (flags.n == flags.v);
         COND_LE: taken = flags.z || (flags.n != flags.v);
         default: taken = 1'b1;
      endcase
   end

endmodule

// File: rtl/flag_unit.sv
// Architectural flag register with EX->ID bypass and registered branch
// decision for the PC-select logic. Define BR_STATS_EN to add saturating
// branch / taken-branch counters (stat_branches, stat_taken).
module flag_unit
   import flag_pkg::*;
#(
   parameter int COND_W = 4,
   parameter int STAT_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ex_valid,
   input  logic              ex_set_flags,
   input  logic              ex_negative,
   input  logic              ex_zero,
   input  logic              ex_overflow,
   input  logic              ex_carry_out,
   input  logic              id_valid,
   input  logic [1:0]        id_br_type,
   input  logic [COND_W-1:0] id_cond,
   input  logic              id_rt_zero,
   input  logic              stall,
   input  logic              flush,
`ifdef BR_STATS_EN
   output logic [STAT_W-1:0] stat_branches,
   output logic [STAT_W-1:0] stat_taken,
`endif
   output logic [3:0]        flags_q,
   output logic              br_valid,
   output logic              br_taken
);

   flags_t   flags_reg;
   flags_t   alu_flags;
   flags_t   eff_flags;
   logic     flag_wr;
   logic     cond_taken;
   logic     br_valid_d;
   logic     take_d;
   logic     advance;
   logic     br_valid_reg;
   logic     br_taken_reg;
   br_type_t id_type;

   assign alu_flags = '{n: ex_negative, z: ex_zero, c: ex_carry_out, v: ex_overflow};
   assign flag_wr   = ex_valid && ex_set_flags;
   // A flag setter in EX is visible to the branch in ID in the same cycle.
   assign eff_flags = flag_wr ? alu_flags : flags_reg;
   assign id_type   = br_type_t'(id_br_type);
   assign advance   = !flush && !stall;

   cond_eval u_cond_eval (
      .flags (eff_flags),
      .cond  (cond_t'(id_cond)),
      .taken (cond_taken)
   );

   // Architectural flags: written by any valid flag-setting EX instruction,
   // regardless of stall/flush (stalls already bubble EX upstream).
   always_ff @(posedge clk) begin
      if (reset) begin
         flags_reg <= FLAG_RESET;
      end else if (flag_wr) begin
         flags_reg <= alu_flags;
      end
   end

   // Branch decision for the instruction in ID; CBZ/CBNZ ignore flags.
   always_comb begin
      br_valid_d = id_valid && (id_type != BR_NONE);
      take_d     = 1'b0;
      case (id_type)
         BR_COND: take_d = cond_taken;
         BR_CBZ:  take_d = id_rt_zero;
         BR_CBNZ: take_d = !id_rt_zero;
         default: take_d = 1'b0;
      endcase
   end

   // ID/EX branch register: flush squashes, stall holds, otherwise advance.
   always_ff @(posedge clk) begin
      if (reset) begin
         br_valid_reg <= 1'b0;
         br_taken_reg <= 1'b0;
      end else if (flush) begin
         br_valid_reg <= 1'b0;
         br_taken_reg <= 1'b0;
      end else if (!stall) begin
         br_valid_reg <= br_valid_d;
         br_taken_reg <= br_valid_d && take_d;
      end
   end

   assign flags_q  = flags_reg;
   assign br_valid = br_valid_reg;
   assign br_taken = br_taken_reg;

`ifdef BR_STATS_EN
   logic [1:0] stat_inc;
   assign stat_inc[0] = br_valid_d;
   assign stat_inc[1] = br_valid_d && take_d;

   for (genvar gi = 0; gi < 2; gi++) begin : g_stat
      logic [STAT_W-1:0] cnt_reg;
      // Saturating event counter, bumped only on an advancing cycle.
      always_ff @(posedge clk) begin
         if (reset) begin
            cnt_reg <= '0;
         end else if (advance && stat_inc[gi] && (cnt_reg != {STAT_W{1'b1}})) begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

   assign stat_branches = g_stat[0].cnt_reg;
   assign stat_taken    = g_stat[1].cnt_reg;
`else
   localparam int unused_stat_w = STAT_W;
   logic unused_advance;
   assign unused_advance = advance;
`endif

endmodule

// File: doc/flag_unit.md
Name: flag_unit

Overview:
- Consumer end of the 64-bit ALU flag interface in the 5-stage LEGv8 pipeline.
- Captures N/Z/V/C from flag-setting EX-stage instructions (ADDS/SUBS/ANDS) into an architectural flags register.
- Evaluates B.cond/CBZ/CBNZ for the instruction in ID, with EX→ID flag bypass.
- Registers the branch decision into the ID/EX boundary for the PC-select logic.

Parameters:
- COND_W, 4, width of condition field (LEGv8 cond encoding)
- STAT_W, 32, width of statistics counters (used only with BR_STATS_EN)

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  synchronous, active-high
- ex_valid  input  1  EX stage holds a real instruction
- ex_set_flags  input  1  EX instruction writes flags
- ex_negative  input  1  ALU negative flag
- ex_zero  input  1  ALU zero flag
- ex_overflow  input  1  ALU overflow flag
- ex_carry_out  input  1  ALU carry_out flag
- id_valid  input  1  ID stage holds a real instruction
- id_br_type  input  2  0 none, 1 B.cond, 2 CBZ, 3 CBNZ
- id_cond  input  COND_W  condition code for B.cond
- id_rt_zero  input  1  forwarded Rt operand equals 64'b0
- stall  input  1  hold ID/EX pipeline register
- flush  input  1  squash ID instruction
- flags_q  output  4  architectural {N,Z,C,V}
- br_valid  output  1  registered: a branch was evaluated last advance
- br_taken  output  1  registered branch decision, aligned with EX

Behaviour:
Reset:
- flags_q = 4'b0000; br_valid = 0; br_taken = 0; stat counters = 0.

Flag write:
- Condition: ex_valid & ex_set_flags at the rising edge.
- Effect: flags_q <= {ex_negative, ex_zero, ex_carry_out, ex_overflow}.
- Independent of stall/flush; stall inserts a bubble into EX upstream (ex_valid=0).

Bypass:
- eff_flags = (ex_valid & ex_set_flags) ? ALU flags : flags_q.
- The branch in ID immediately after a flag setter sees the new flags with zero penalty.

Condition decode (on eff_flags):
- 0 EQ Z; 1 NE !Z
- 2 HS C; 3 LO !C
- 4 MI N; 5 PL !N
- 6 VS V; 7 VC !V
- 8 HI C&!Z; 9 LS !C|Z
- 10 GE N==V; 11 LT N!=V
- 12 GT !Z&(N==V); 13 LE Z|(N!=V)
- 14, 15 always.
- C=1 on subtract means no borrow (ALU computes A+~B+1).

Branch evaluation (combinational):
- take_d = B.cond: cond(id_cond); CBZ: id_rt_zero; CBNZ: !id_rt_zero; none: 0.
- CBZ/CBNZ ignore flags.

Branch register, priority reset > flush > stall > advance:
- flush: br_valid <= 0, br_taken <= 0.
- stall (no flush): br_valid and br_taken hold.
- advance: br_valid <= id_valid & (id_br_type != 0); br_taken <= br_valid_d & take_d.
- Stall and flush together: flush wins.
- Reset mid-operation discards any pending branch and flags.
- Latency: ID decision appears on br_taken one cycle later; flag write is visible on flags_q one cycle later, and via bypass in the same cycle.

Optional Feature:
BR_STATS_EN:
- Defined: adds outputs stat_branches and stat_taken (STAT_W each).
- Both increment on each advance with br_valid_d / br_valid_d & take_d, and saturate at all-ones.
- Both clear on reset and are unaffected by stall cycles.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package flag_pkg:
  - br_type_t enum (BR_NONE, BR_COND, BR_CBZ, BR_CBNZ)
  - cond_t enum of 16 codes
  - flags_t packed struct {n, z, c, v}
  - FLAG_RESET constant
- Sub-module cond_eval: pure combinational flags_t + cond_t -> taken; reused by a later predicated-move block.

Test Plan:
1. Reset held 2 cycles -> flags_q=0000, br_valid=0, br_taken=0.
2. SUBS with ALU flags N=0,Z=1,C=1,V=0 in EX, same cycle B.EQ in ID -> next cycle br_valid=1, br_taken=1 via bypass; flags_q=0110.
3. flags_q=1000 (N=1,V=0), B.GE then B.LT on consecutive advances -> br_taken 0 then 1; GT with Z=1 -> 0.
4. CBZ with id_rt_zero=1 and id_cond=NE, flags Z=1 -> taken=1; CBNZ same operand -> 0.
5. Taken B.AL, then stall 3 cycles -> br_* hold 1/1; stall+flush -> br_valid=0 next cycle.
6. ex_set_flags=1 with ex_valid=0 -> flags_q unchanged. With BR_STATS_EN: 5 branches, 3 taken -> stat_branches=5, stat_taken=3; preload near saturation -> holds at all-ones.
